// File: rtl/param_calculator.sv
// param_calculator: small register file with a single-cycle ALU and a
// shift-add multiplier; operations are accepted only while IDLE.
module param_calculator #(
    parameter  int WIDTH  = 8,
    parameter  int NREGS  = 4,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  immediate,
    input  logic [ADDR_W-1:0] we_addr,
    input  logic [3:0]        control,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic               done_q, z_q, c_q;
    logic               accept, mul_last;
    logic [WIDTH-1:0]   op_a, alu_res;
    logic               alu_c;
    logic [WIDTH:0]     sum;
    logic               wr_en, wr_c;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WIDTH-1:0]   wr_data;

    assign op_a     = regs_q[rd_addr];
    assign rd_data  = regs_q[rd_addr];
    assign accept   = in_valid && in_ready;
    assign mul_last = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH-1));
    assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = done_q;
    assign flag_z   = z_q;
    assign flag_c   = c_q;

    // SUB shares the adder: A + ~B + 1, carry-out means no borrow
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (control[2:0])
            3'b000: alu_res = op_a & immediate;
            3'b001: alu_res = op_a | immediate;
            3'b010: begin
                sum     = {1'b0, op_a} + {1'b0, immediate};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'b011: alu_res = WIDTH'(op_a < immediate);
            3'b100: alu_res = op_a & ~immediate;
            3'b101: alu_res = op_a | ~immediate;
            3'b110: begin
                sum     = {1'b0, op_a} + {1'b0, ~immediate} + (WIDTH+1)'(1);
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'b111: alu_res = WIDTH'($signed(op_a) < $signed(immediate));
            default: ;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = we_addr;
        wr_data = alu_res;
        wr_c    = alu_c;
        if (mul_last) begin
            wr_en   = 1'b1;
            wr_addr = waddr_q;
            wr_data = acc_d[WIDTH-1:0];
            wr_c    = |acc_d[2*WIDTH-1:WIDTH];
        end else if (accept && !control[3]) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && control[3]) state_d = MUL;
            MUL:     if (mul_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == MUL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            waddr_q  <= '0;
            done_q   <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            done_q <= wr_en;
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
                z_q             <= (wr_data == '0);
                c_q             <= wr_c;
            end
            if (accept && control[3]) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, op_a};
                mplier_q <= immediate;
                cnt_q    <= '0;
                waddr_q  <= we_addr;
            end else if (state_q == MUL) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule
